// File: rtl/btn_conditioner.sv
// Synchronizes, debounces and edge-detects the stopwatch pushbuttons and
// slide switches; also keeps the pause toggle state.
module btn_conditioner #(
  parameter int unsigned STABLE_CNT = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRst,
  input  logic btnPause,
  input  logic swADJ,
  input  logic swSEL,
  output logic RESET,
  output logic resetPulse,
  output logic pausePulse,
  output logic paused,
  output logic ADJ,
  output logic SEL
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       stb_q;
  logic [3:0]       stb_d;
  logic [3:0]       rise_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             rst_pulse_q;
  logic             pause_pulse_q;
  logic             paused_q;
  logic             paused_d;

  // Bit order: 0 btnRst, 1 btnPause, 2 swADJ, 3 swSEL
  assign raw = {swSEL, swADJ, btnPause, btnRst};

  always_comb begin
    stb_d  = stb_q;
    rise_d = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stb_q[i]) begin
        if (cnt_q[i] == LAST) begin
          stb_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A reset press wins over a simultaneous pause press
  always_comb begin
    paused_d = paused_q;
    if (rise_d[0]) begin
      paused_d = 1'b0;
    end else if (rise_d[1]) begin
      paused_d = ~paused_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stb_q         <= '0;
      rst_pulse_q   <= 1'b0;
      pause_pulse_q <= 1'b0;
      paused_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stb_q         <= stb_d;
      rst_pulse_q   <= rise_d[0];
      pause_pulse_q <= rise_d[1];
      paused_q      <= paused_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign RESET      = stb_q[0];
  assign ADJ        = stb_q[2];
  assign SEL        = stb_q[3];
  assign resetPulse = rst_pulse_q;
  assign pausePulse = pause_pulse_q;
  assign paused     = paused_q;

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 500000, consecutive clk cycles a synchronized input must differ from its debounced value before that value updates (5 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 20, width of each debounce counter.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port btnRst  input  1  raw asynchronous reset pushbutton, active-high.
REQ-006 SHALL have port btnPause  input  1  raw asynchronous pause pushbutton, active-high.
REQ-007 SHALL have port swADJ  input  1  raw asynchronous adjust slide switch.
REQ-008 SHALL have port swSEL  input  1  raw asynchronous select slide switch.
REQ-009 SHALL have port RESET  output  1  debounced level of btnRst, feeds timer RESET.
REQ-010 SHALL have port resetPulse  output  1  one-cycle strobe on debounced btnRst rising edge.
REQ-011 SHALL have port pausePulse  output  1  one-cycle strobe on debounced btnPause rising edge.
REQ-012 SHALL have port paused  output  1  pause toggle state, 1 = stopwatch halted.
REQ-013 SHALL have port ADJ  output  1  debounced level of swADJ.
REQ-014 SHALL have port SEL  output  1  debounced level of swSEL.

Function
REQ-015 SHALL pass each of the four raw inputs through its own two-flop synchronizer (sync1, sync2) before any other logic.
REQ-016 SHALL keep, per input, a debounced value stb and a CNT_W-bit counter cnt.
REQ-017 SHALL, each edge where sync2 == stb, clear cnt to 0 and hold stb.
REQ-018 SHALL, each edge where sync2 != stb and cnt < STABLE_CNT-1, increment cnt by 1.
REQ-019 SHALL, at the edge where sync2 != stb and cnt == STABLE_CNT-1, load stb <= sync2 and clear cnt; cnt never wraps.
REQ-020 SHALL, for a clean raw transition, update stb at the (STABLE_CNT+2)th rising edge, counting the first edge that samples the new raw value as edge 1.
REQ-021 SHALL reject any glitch shorter than STABLE_CNT synchronized cycles; one cycle of sync2 == stb restarts the count from 0.
REQ-022 SHALL register resetPulse/pausePulse high for exactly one cycle, set at the same edge the respective stb goes 0->1; no pulse on 1->0.
REQ-023 SHALL toggle paused at the edge pausePulse is set.
REQ-024 SHALL clear paused to 0 at the edge resetPulse is set, overriding a simultaneous pausePulse (resetPulse still asserts; pausePulse still asserts).
REQ-025 SHALL drive RESET, ADJ, SEL directly from their stb registers (no additional latency).
REQ-026 SHALL hold all per-input state independent; activity on one input never alters another's counter.

Reset
REQ-027 SHALL, at any rising edge with rst == 0, force all sync1, sync2, stb, cnt, resetPulse, pausePulse and paused to 0, regardless of raw inputs.
REQ-028 SHALL treat reset mid-debounce as full abort: partial counts are discarded, no pulse emitted.
REQ-029 SHALL, after rst returns to 1 with a raw input already high, debounce it as a fresh 0->1 transition (pulse emitted after STABLE_CNT+2 edges).

Verification (STABLE_CNT = 4)
REQ-030 SHALL cover: rst=0 for 3 edges with all raw inputs 1 -> all outputs 0 throughout; after release, RESET/ADJ/SEL = 1 and resetPulse one cycle at edge 6.
REQ-031 SHALL cover: btnPause 0->1 held -> pausePulse high for exactly one cycle at edge 6, paused 0->1 same edge; second clean press -> paused 1->0.
REQ-032 SHALL cover: btnPause toggled every 2 cycles for 20 cycles then held 0 -> pausePulse never asserts, paused unchanged.
REQ-033 SHALL cover: btnRst and btnPause rise same cycle with paused=1 -> resetPulse and pausePulse both one cycle at edge 6, paused = 0.
REQ-034 SHALL cover: btnPause rises, rst=0 at edge 4 (cnt == 2) -> no pausePulse, cnt 0; rst=1 with btnPause held -> pausePulse at edge 6 after release.
REQ-035 SHALL cover: swADJ 1 then 0, each held 10 cycles -> ADJ follows at edge 6 of each transition, no pulse outputs affected.
